// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: write-FSM state encoding, burst/response codes,
// and the AxSIZE helper used by AXI4 masters in this codebase.
package axi4_pkg;

  // Write-master sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AxSIZE encoding for a power-of-two beat size in bytes (1..128)
  function automatic logic [2:0] axi_size_from_bytes(input int unsigned nbytes);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == nbytes) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/axi4_ring_writer.sv
// AXI4 ring-buffer writer: streams samples from an AXI-Stream-like input
// into a power-of-two byte ring at base_addr using fixed-length INCR bursts.
// Optional statistics outputs (burst_count, wrap_count) are built only when
// AXI4_RING_WRITER_STATS_EN is defined.
module axi4_ring_writer
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int RING_LOG2  = 12
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [RING_LOG2-1:0]    wr_ptr,
  output logic                    busy,
  output logic                    error
`ifdef AXI4_RING_WRITER_STATS_EN
  ,
  output logic [31:0]             burst_count,
  output logic [15:0]             wrap_count
`endif
);

  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int BURST_BYTES    = BURST_LEN * BYTES_PER_BEAT;
  localparam int BEAT_W         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  // A burst that fills the whole ring truncates to 0 here, which still
  // lands every burst back on offset 0 as required.
  localparam logic [RING_LOG2-1:0] BURST_STEP = RING_LOG2'(BURST_BYTES);
  localparam logic [2:0]           AW_SIZE    = axi_size_from_bytes(BYTES_PER_BEAT);

  wr_state_e             state, state_nxt;
  logic [RING_LOG2-1:0]  offset;
  logic [RING_LOG2-1:0]  offset_nxt;
  logic [BEAT_W-1:0]     beat_cnt;
  logic                  enable_q;
  logic                  aw_hs, w_hs, b_hs;
  logic                  ring_wrap;

  assign aw_hs      = m_axi_awvalid & m_axi_awready;
  assign w_hs       = m_axi_wvalid & m_axi_wready;
  assign b_hs       = m_axi_bvalid & m_axi_bready;
  assign offset_nxt = offset + BURST_STEP;
  assign ring_wrap  = (offset_nxt == '0);

  // Static burst attributes; address is stable while in ADDR because
  // offset only moves on the B handshake.
  assign m_axi_awaddr  = base_addr | ADDR_WIDTH'(offset);
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = AW_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = s_tdata;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; a burst, once addressed, always runs to its response
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (otherwise a latch is inferred).
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (enable)               state_nxt = ST_ADDR;
      ST_ADDR: if (aw_hs)                state_nxt = ST_DATA;
      ST_DATA: if (w_hs && m_axi_wlast)  state_nxt = ST_RESP;
      ST_RESP: if (b_hs)                 state_nxt = enable ? ST_ADDR : ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  // Per-state handshake outputs; stream is wired straight through in DATA
  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    s_tready      = 1'b0;
    busy          = 1'b1;
    unique case (state)
      ST_IDLE: busy = 1'b0;
      ST_ADDR: m_axi_awvalid = 1'b1;
      ST_DATA: begin
        m_axi_wvalid = s_tvalid;
        s_tready     = m_axi_wready;
        m_axi_wlast  = (beat_cnt == LAST_BEAT);
      end
      ST_RESP: m_axi_bready = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Beat counter: advances only on completed W beats, rewinds after wlast
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  beat_cnt <= '0;
    else if (w_hs) beat_cnt <= m_axi_wlast ? '0 : beat_cnt + 1'b1;
  end

  // Ring offset and published write pointer move together on the B handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      offset <= '0;
      wr_ptr <= '0;
    end else if (b_hs) begin
      offset <= offset_nxt;
      wr_ptr <= offset_nxt;
    end
  end

  // Sticky error; cleared only by a fresh enable request while idle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      enable_q <= 1'b0;
      error    <= 1'b0;
    end else begin
      enable_q <= enable;
      if (b_hs && (m_axi_bresp != AXI_RESP_OKAY))
        error <= 1'b1;
      else if ((state == ST_IDLE) && enable && !enable_q)
        error <= 1'b0;
    end
  end

`ifdef AXI4_RING_WRITER_STATS_EN
  // Completed-burst and ring-wrap counters, both free-running
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      burst_count <= '0;
      wrap_count  <= '0;
    end else if (b_hs) begin
      burst_count <= burst_count + 32'd1;
      if (ring_wrap) wrap_count <= wrap_count + 16'd1;
    end
  end
`else
  // Wrap detection only feeds the statistics counters
  logic unused_wrap;
  assign unused_wrap = ring_wrap;
`endif

endmodule

// File: tb/tb_axi4_ring_writer.sv
// Directed bench for axi4_ring_writer: a 256-byte ring with 64-byte bursts,
// an AXI slave model with optional random ready/response delays, and a
// counting source. Stats checks compile in with AXI4_RING_WRITER_STATS_EN.
module tb_axi4_ring_writer;
  import axi4_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BL = 16;
  localparam int RL = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            enable;
  logic [AW-1:0]   base_addr;
  logic [DW-1:0]   s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic [AW-1:0]   m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid;
  logic            m_axi_bready;
  logic [RL-1:0]   wr_ptr;
  logic            busy;
  logic            error;
`ifdef AXI4_RING_WRITER_STATS_EN
  logic [31:0]     burst_count;
  logic [15:0]     wrap_count;
`endif

  axi4_ring_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .RING_LOG2(RL)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .base_addr(base_addr),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .wr_ptr(wr_ptr), .busy(busy), .error(error)
`ifdef AXI4_RING_WRITER_STATS_EN
    , .burst_count(burst_count), .wrap_count(wrap_count)
`endif
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Slave / source model state
  bit            bp_en = 1'b0;
  int            slverr_burst = 0;
  int            src_idx = 0;
  int            beats = 0;
  int            bursts_done = 0;
  int            aw_cnt = 0;
  int            burst_beat = 0;
  int            aw_dly = 0, w_dly = 0, b_dly = 0;
  bit            b_pending = 1'b0;
  logic [RL-1:0] cur_off = '0;
  logic [31:0]   aw_log[$];
  logic [DW-1:0] mem [64];

  // Slave + source: drive at negedge+1, record the handshakes that the
  // following posedge will complete at negedge+2.
  initial begin
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp = AXI_RESP_OKAY; s_tvalid = 1'b0; s_tdata = '0;
    forever begin
      @(negedge aclk);
      #1;
      if (!aresetn) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        s_tvalid = 1'b0; b_pending = 1'b0; burst_beat = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0;
      end else begin
        s_tvalid = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_tdata  = pat(src_idx);
        m_axi_awready = 1'b0;
        if (m_axi_awvalid) begin
          if (aw_dly == 0) m_axi_awready = 1'b1;
          else             aw_dly--;
        end
        m_axi_wready = (w_dly == 0);
        if (w_dly != 0) w_dly--;
        m_axi_bvalid = 1'b0;
        if (b_pending) begin
          if (b_dly == 0) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = (bursts_done + 1 == slverr_burst) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          end else b_dly--;
        end
        #1;
        if (m_axi_awvalid && m_axi_awready) begin
          aw_log.push_back(m_axi_awaddr);
          cur_off = m_axi_awaddr[RL-1:0];
          aw_cnt++;
          aw_dly = bp_en ? int'($urandom_range(0, 7)) : 0;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          int wi;
          check("wdata", 64'(m_axi_wdata), 64'(pat(src_idx)));
          check("wlast", 64'(m_axi_wlast), 64'(burst_beat == BL - 1));
          wi = (int'(cur_off) / 4 + burst_beat) % 64;
          mem[wi[5:0]] = m_axi_wdata;
          src_idx++;
          beats++;
          w_dly = bp_en ? int'($urandom_range(0, 7)) : 0;
          if (m_axi_wlast) begin
            burst_beat = 0;
            b_pending  = 1'b1;
            b_dly      = bp_en ? int'($urandom_range(0, 7)) : 0;
          end else burst_beat++;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          bursts_done++;
          b_pending = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    enable  = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic clear_counts();
    beats = 0; bursts_done = 0; aw_cnt = 0;
    aw_log.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_aw(input string tag);
    for (int i = 0; i < 100 && !m_axi_awvalid; i++) tick();
    check({tag, "_awvalid"}, 64'(m_axi_awvalid), 64'd1);
  endtask

  logic [31:0] wrap_exp [5];
  int start_idx;

  initial begin
    wrap_exp = '{32'h00, 32'h40, 32'h80, 32'hC0, 32'h00};
    aresetn   = 1'b0;
    enable    = 1'b0;
    base_addr = BASE;

    // Reset state
    tick(); tick();
    check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("rst_wvalid",  64'(m_axi_wvalid),  64'd0);
    check("rst_bready",  64'(m_axi_bready),  64'd0);
    check("rst_tready",  64'(s_tready),      64'd0);
    check("rst_busy",    64'(busy),          64'd0);
    check("rst_wr_ptr",  64'(wr_ptr),        64'd0);
    check("rst_error",   64'(error),         64'd0);
    aresetn = 1'b1;
    tick();

    // Basic single burst
    clear_counts();
    enable = 1'b1;
    wait_aw("basic");
    check("basic_awaddr",  64'(m_axi_awaddr),  64'h4000_0000);
    check("basic_awlen",   64'(m_axi_awlen),   64'd15);
    check("basic_awsize",  64'(m_axi_awsize),  64'd2);
    check("basic_awburst", 64'(m_axi_awburst), 64'd1);
    check("basic_wstrb",   64'(m_axi_wstrb),   64'hF);
    check("basic_busy",    64'(busy),          64'd1);
    enable = 1'b0;
    wait_idle("basic", 200);
    check("basic_beats",  64'(beats),       64'd16);
    check("basic_bursts", 64'(bursts_done), 64'd1);
    check("basic_wr_ptr", 64'(wr_ptr),      64'h40);

    // Ring wrap over five bursts
    do_reset();
    clear_counts();
    enable = 1'b1;
    for (int i = 0; i < 1000 && aw_cnt < 5; i++) tick();
    enable = 1'b0;
    wait_idle("wrap", 200);
    check("wrap_aw_cnt", 64'(aw_cnt), 64'd5);
    for (int k = 0; k < 5 && k < aw_log.size(); k++)
      check($sformatf("wrap_awaddr%0d", k), 64'(aw_log[k]), 64'(BASE | wrap_exp[k]));
    check("wrap_wr_ptr", 64'(wr_ptr), 64'h40);
`ifdef AXI4_RING_WRITER_STATS_EN
    check("wrap_count",  64'(wrap_count),  64'd1);
    check("burst_count", 64'(burst_count), 64'd5);
`endif

    // Backpressure: four bursts fill the ring exactly once
    do_reset();
    clear_counts();
    for (int k = 0; k < 64; k++) mem[k] = 32'hDEAD_BEEF;
    start_idx = src_idx;
    bp_en  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 5000 && aw_cnt < 4; i++) tick();
    enable = 1'b0;
    wait_idle("bp", 3000);
    bp_en = 1'b0;
    check("bp_beats",  64'(beats),       64'd64);
    check("bp_bursts", 64'(bursts_done), 64'd4);
    for (int k = 0; k < 64; k++)
      check($sformatf("bp_mem%0d", k), 64'(mem[k]), 64'(pat(start_idx + k)));

    // SLVERR on burst 2
    do_reset();
    clear_counts();
    slverr_burst = 2;
    enable = 1'b1;
    for (int i = 0; i < 500 && bursts_done < 1; i++) tick();
    check("err_after_b1", 64'(error), 64'd0);
    for (int i = 0; i < 500 && bursts_done < 2; i++) tick();
    check("err_after_b2", 64'(error), 64'd1);
    for (int i = 0; i < 500 && bursts_done < 3; i++) tick();
    check("err_continue", 64'(bursts_done), 64'd3);
    check("err_sticky",   64'(error),       64'd1);
    enable = 1'b0;
    wait_idle("err", 200);
    check("err_idle", 64'(error), 64'd1);
    slverr_burst = 0;
    enable = 1'b1;
    tick();
    check("err_clear", 64'(error), 64'd0);
    enable = 1'b0;
    wait_idle("err2", 200);

    // Enable dropped at beat 5
    do_reset();
    clear_counts();
    enable = 1'b1;
    for (int i = 0; i < 200 && beats < 5; i++) tick();
    enable = 1'b0;
    wait_idle("drop", 200);
    check("drop_beats",  64'(beats),       64'd16);
    check("drop_bursts", 64'(bursts_done), 64'd1);
    check("drop_aw_cnt", 64'(aw_cnt),      64'd1);

    // Reset pulsed at beat 8 of a burst that started at offset 0x40
    clear_counts();
    enable = 1'b1;
    for (int i = 0; i < 200 && beats < 8; i++) tick();
    check("mid_pre_awaddr", 64'(aw_log.size() > 0 ? aw_log[0] : 32'h0), 64'(BASE | 32'h40));
    aresetn = 1'b0;
    tick();
    check("mid_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("mid_wvalid",  64'(m_axi_wvalid),  64'd0);
    check("mid_tready",  64'(s_tready),      64'd0);
    check("mid_bready",  64'(m_axi_bready),  64'd0);
    check("mid_busy",    64'(busy),          64'd0);
    check("mid_wr_ptr",  64'(wr_ptr),        64'd0);
    check("mid_error",   64'(error),         64'd0);
`ifdef AXI4_RING_WRITER_STATS_EN
    check("mid_burst_count", 64'(burst_count), 64'd0);
`endif
    clear_counts();
    aresetn = 1'b1;
    wait_aw("mid");
    check("mid_next_awaddr", 64'(m_axi_awaddr), 64'(BASE));
    enable = 1'b0;
    wait_idle("mid", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_ring_writer.md
AXI4_RING_WRITER -- requirements
Module: axi4_ring_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning AXI4 W-channel and stream data width in bits (32, 64 or 128).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI4 address width.
REQ-003 SHALL have parameter BURST_LEN, default 16, meaning beats per burst (power of 2, 1..256).
REQ-004 SHALL have parameter RING_LOG2, default 12, meaning log2 of the ring size in bytes (RING_LOG2 >= log2(BURST_LEN*DATA_WIDTH/8)).
REQ-005 SHALL have the ports: aclk in 1 clock; aresetn in 1 async active-low reset; enable in 1 run request; base_addr in ADDR_WIDTH ring base (ring-size aligned); s_tdata in DATA_WIDTH sample data; s_tvalid in 1; s_tready out 1; m_axi_aw* (awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awvalid, awready); m_axi_w* (wdata, wstrb, wlast, wvalid, wready); m_axi_b* (bresp[1:0], bvalid, bready); wr_ptr out RING_LOG2 byte offset of the last completed burst end; busy out 1; error out 1 sticky.

Function
REQ-006 SHALL use a state machine IDLE, ADDR, DATA, RESP: IDLE->ADDR when enable=1; ADDR->DATA on awvalid&awready; DATA->RESP on the wlast beat handshake; RESP->ADDR on bvalid&bready if enable=1, else RESP->IDLE.
REQ-007 SHALL drive awlen=BURST_LEN-1, awsize=log2(DATA_WIDTH/8), awburst=INCR (01), and wstrb all ones.
REQ-008 SHALL form awaddr = base_addr | offset, where offset is RING_LOG2 bits and advances by BURST_LEN*DATA_WIDTH/8 per burst, wrapping modulo 2^RING_LOG2 with no bubble cycle at wrap.
REQ-009 SHALL pass data combinationally in DATA: wvalid=s_tvalid, s_tready=wready, wdata=s_tdata; s_tready=0 in all other states.
REQ-010 SHALL count beats with a counter and assert wlast exactly on beat BURST_LEN-1; a beat completes only on wvalid&wready.
REQ-011 SHALL hold awvalid high in ADDR until the handshake, with awaddr stable.
REQ-012 SHALL assert bready=1 only in RESP; it SHALL update wr_ptr to the burst end offset one cycle after the B handshake.
REQ-013 SHALL set error on bresp!=OKAY; error SHALL clear only on reset or on the enable 0->1 edge while in IDLE.
REQ-014 SHALL finish any burst in progress when enable falls mid-burst and only then return to IDLE, never truncating a burst.
REQ-015 SHALL assert busy=1 in every state except IDLE.

Reset
REQ-016 SHALL asynchronously reset, when aresetn=0, to IDLE with offset=0, wr_ptr=0, beat counter=0, error=0, and awvalid, wvalid, bready, s_tready, busy all 0.
REQ-017 SHALL discard any burst in progress when reset arrives mid-burst; after release it SHALL restart at offset 0.

Configuration
REQ-018 SHALL instantiate, when macro AXI4_RING_WRITER_STATS_EN is defined, outputs burst_count[31:0], which counts completed B handshakes and wraps, and wrap_count[15:0], which counts ring wraps; both SHALL reset to 0.
REQ-019 SHALL omit both ports and their logic entirely when the macro is undefined.

Structure
REQ-020 SHALL take from shared package axi4_pkg: the state enum, the AXI_BURST_INCR constant, the AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants, and the function computing awsize from a byte count.
REQ-021 SHALL contain no sub-module; the beat counter and offset logic SHALL be inline.

Verification
REQ-022 Bench SHALL cover basic operation: DATA_WIDTH=32, BURST_LEN=16, base=0x4000_0000, enable=1, continuous data -> first awaddr=0x4000_0000, awlen=15, awsize=2, wlast on the 16th beat, wr_ptr=0x040.
REQ-023 Bench SHALL cover wrap-around: RING_LOG2=8 with 64-byte bursts, 5 bursts -> awaddr sequence 0x00, 0x40, 0x80, 0xC0, 0x00; wrap_count=1 when STATS_EN is defined.
REQ-024 Bench SHALL cover backpressure: random wready/awready/bvalid delays of 0-7 cycles -> no lost or duplicated beats; memory contents equal the input sequence.
REQ-025 Bench SHALL cover error response: slave returns SLVERR on burst 2 -> error=1 and stays 1; operation continues; error clears on the next enable edge from IDLE.
REQ-026 Bench SHALL cover mid-operation events: enable dropped at beat 5 -> burst completes with 16 beats, then IDLE and busy=0; aresetn pulsed at beat 8 -> all outputs at reset values, next awaddr=base.
